// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder and its full-adder cell.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Full-adder truth tables, indexed by {a, b, cin}.
    localparam logic [7:0] FA_SUM_TT   = 8'b1001_0110;
    localparam logic [7:0] FA_CARRY_TT = 8'b1110_1000;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Purely combinational 1-bit full-adder cell; sum and carry are 8:1 mux truth tables.
module fa_bit
    import serial_add_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic [2:0] sel;

    always_comb begin
        sel   = {a, b, cin};
        sum   = FA_SUM_TT[sel];
        carry = FA_CARRY_TT[sel];
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one fa_bit cell, LSB-first, registered carry.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_t         state;
    state_t         next_state;
    logic           load;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           fa_s;
    logic           fa_c;

    fa_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_s),
        .carry(fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // sum is the result shift register itself, so it holds until the next load starts shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            sum   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= CNT_LOAD;
        end else if (state == RUN) begin
            sum   <= {fa_s, sum[WIDTH-1:1]};
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            carry <= fa_c;
            cnt   <= cnt - 1'b1;
            if (cnt == '0) begin
                cout <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                // carry still holds the MSB cell's carry-in on this edge
                ovf  <= carry ^ fa_c;
`endif
            end
        end
    end

endmodule
